// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared Hack keyboard constants, PS/2 set-2 prefix codes and decoder state type.
package hack_keys_pkg;

    localparam logic [7:0] HK_NEWLINE   = 8'd128;
    localparam logic [7:0] HK_BACKSPACE = 8'd129;
    localparam logic [7:0] HK_LEFT      = 8'd130;
    localparam logic [7:0] HK_UP        = 8'd131;
    localparam logic [7:0] HK_RIGHT     = 8'd132;
    localparam logic [7:0] HK_DOWN      = 8'd133;
    localparam logic [7:0] HK_HOME      = 8'd134;
    localparam logic [7:0] HK_END       = 8'd135;
    localparam logic [7:0] HK_PGUP      = 8'd136;
    localparam logic [7:0] HK_PGDN      = 8'd137;
    localparam logic [7:0] HK_INSERT    = 8'd138;
    localparam logic [7:0] HK_DELETE    = 8'd139;
    localparam logic [7:0] HK_ESC       = 8'd140;
    localparam logic [7:0] HK_F1        = 8'd141;
    localparam logic [7:0] HK_F2        = 8'd142;
    localparam logic [7:0] HK_F3        = 8'd143;
    localparam logic [7:0] HK_F4        = 8'd144;
    localparam logic [7:0] HK_F5        = 8'd145;
    localparam logic [7:0] HK_F6        = 8'd146;
    localparam logic [7:0] HK_F7        = 8'd147;
    localparam logic [7:0] HK_F8        = 8'd148;
    localparam logic [7:0] HK_F9        = 8'd149;
    localparam logic [7:0] HK_F10       = 8'd150;
    localparam logic [7:0] HK_F11       = 8'd151;
    localparam logic [7:0] HK_F12       = 8'd152;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;

    typedef enum logic [2:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0_F0,
        SKIP
    } dec_state_t;

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Byte stream in, Hack key word out; master is the receiver/register side, slave the decoder.
interface ps2_scancode_decoder_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] key_code;
    logic        key_event;

    modport master (output rx_data, output rx_valid, input key_code, input key_event);
    modport slave  (input rx_data, input rx_valid, output key_code, output key_event);
endinterface

// File: rtl/ps2_scancode_decoder_lut.sv
// Combinational scan-code to Hack-code table; each entry holds {unshifted, shifted} codes.
module scancode_lut
    import hack_keys_pkg::*;
(
    input  logic       i_ext,
    input  logic [7:0] i_sc,
    input  logic       i_shift,
    output logic [7:0] o_code,
    output logic       o_mapped
);

    logic [15:0] w_pair;

    always_comb begin
        w_pair   = 16'h0000;
        o_mapped = 1'b1;
        if (i_ext) begin
            case (i_sc)
                8'h5A:   w_pair = {2{HK_NEWLINE}};
                8'h6B:   w_pair = {2{HK_LEFT}};
                8'h75:   w_pair = {2{HK_UP}};
                8'h74:   w_pair = {2{HK_RIGHT}};
                8'h72:   w_pair = {2{HK_DOWN}};
                8'h6C:   w_pair = {2{HK_HOME}};
                8'h69:   w_pair = {2{HK_END}};
                8'h7D:   w_pair = {2{HK_PGUP}};
                8'h7A:   w_pair = {2{HK_PGDN}};
                8'h70:   w_pair = {2{HK_INSERT}};
                8'h71:   w_pair = {2{HK_DELETE}};
                default: o_mapped = 1'b0;
            endcase
        end else begin
            case (i_sc)
                8'h1C: w_pair = "aA";   8'h32: w_pair = "bB";   8'h21: w_pair = "cC";
                8'h23: w_pair = "dD";   8'h24: w_pair = "eE";   8'h2B: w_pair = "fF";
                8'h34: w_pair = "gG";   8'h33: w_pair = "hH";   8'h43: w_pair = "iI";
                8'h3B: w_pair = "jJ";   8'h42: w_pair = "kK";   8'h4B: w_pair = "lL";
                8'h3A: w_pair = "mM";   8'h31: w_pair = "nN";   8'h44: w_pair = "oO";
                8'h4D: w_pair = "pP";   8'h15: w_pair = "qQ";   8'h2D: w_pair = "rR";
                8'h1B: w_pair = "sS";   8'h2C: w_pair = "tT";   8'h3C: w_pair = "uU";
                8'h2A: w_pair = "vV";   8'h1D: w_pair = "wW";   8'h22: w_pair = "xX";
                8'h35: w_pair = "yY";   8'h1A: w_pair = "zZ";
                8'h16: w_pair = "1!";   8'h1E: w_pair = "2@";   8'h26: w_pair = "3#";
                8'h25: w_pair = "4$";   8'h2E: w_pair = "5%";   8'h36: w_pair = "6^";
                8'h3D: w_pair = "7&";   8'h3E: w_pair = "8*";   8'h46: w_pair = "9(";
                8'h45: w_pair = "0)";
                8'h0E: w_pair = {8'h60, 8'h7E};
                8'h4E: w_pair = "-_";   8'h55: w_pair = "=+";   8'h54: w_pair = "[{";
                8'h5B: w_pair = "]}";   8'h5D: w_pair = "\\|";  8'h4C: w_pair = ";:";
                8'h52: w_pair = "'\"";  8'h41: w_pair = ",<";   8'h49: w_pair = ".>";
                8'h4A: w_pair = "/?";   8'h29: w_pair = "  ";
                8'h5A: w_pair = {2{HK_NEWLINE}};
                8'h66: w_pair = {2{HK_BACKSPACE}};
                8'h76: w_pair = {2{HK_ESC}};
                8'h05: w_pair = {2{HK_F1}};   8'h06: w_pair = {2{HK_F2}};
                8'h04: w_pair = {2{HK_F3}};   8'h0C: w_pair = {2{HK_F4}};
                8'h03: w_pair = {2{HK_F5}};   8'h0B: w_pair = {2{HK_F6}};
                8'h83: w_pair = {2{HK_F7}};   8'h0A: w_pair = {2{HK_F8}};
                8'h01: w_pair = {2{HK_F9}};   8'h09: w_pair = {2{HK_F10}};
                8'h78: w_pair = {2{HK_F11}};  8'h07: w_pair = {2{HK_F12}};
                default: o_mapped = 1'b0;
            endcase
        end
        o_code = i_shift ? w_pair[7:0] : w_pair[15:8];
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 byte stream to Hack keyboard word: prefix FSM, Pause skipping, shift and held-key tracking.
module ps2_scancode_decoder
    import hack_keys_pkg::*;
#(
    parameter int SKIP_E1 = 7
) (
    input logic                   clk,
    input logic                   rst_n,
    ps2_scancode_decoder_if.slave bus
);

    localparam int CW = (SKIP_E1 > 1) ? $clog2(SKIP_E1) : 1;

    dec_state_t    r_state, w_stateNext;
    logic [CW-1:0] r_skipCnt, w_skipCntNext;
    logic          r_shiftL, w_shiftLNext;
    logic          r_shiftR, w_shiftRNext;
    logic          r_heldValid, w_heldValidNext;
    logic [8:0]    r_held, w_heldNext;
    logic [15:0]   r_keyCode, w_keyCodeNext;
    logic          r_keyEvent;

    logic          w_doMake, w_doBreak, w_ext, w_mapped;
    logic [7:0]    w_lutCode;

    scancode_lut u_lut (
        .i_ext    (w_ext),
        .i_sc     (bus.rx_data),
        .i_shift  (r_shiftL | r_shiftR),
        .o_code   (w_lutCode),
        .o_mapped (w_mapped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_skipCnt   <= '0;
            r_shiftL    <= 1'b0;
            r_shiftR    <= 1'b0;
            r_heldValid <= 1'b0;
            r_held      <= 9'h000;
            r_keyCode   <= 16'h0000;
            r_keyEvent  <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_skipCnt   <= w_skipCntNext;
            r_shiftL    <= w_shiftLNext;
            r_shiftR    <= w_shiftRNext;
            r_heldValid <= w_heldValidNext;
            r_held      <= w_heldNext;
            r_keyCode   <= w_keyCodeNext;
            r_keyEvent  <= (w_keyCodeNext != r_keyCode);
        end
    end

    // Prefix decoding picks make/break and the extended flag; key effects follow below.
    always_comb begin
        w_stateNext     = r_state;
        w_skipCntNext   = r_skipCnt;
        w_shiftLNext    = r_shiftL;
        w_shiftRNext    = r_shiftR;
        w_heldValidNext = r_heldValid;
        w_heldNext      = r_held;
        w_keyCodeNext   = r_keyCode;
        w_doMake        = 1'b0;
        w_doBreak       = 1'b0;
        w_ext           = 1'b0;

        if (bus.rx_valid) begin
            case (r_state)
                IDLE: begin
                    if (bus.rx_data == SC_E0) begin
                        w_stateNext = GOT_E0;
                    end else if (bus.rx_data == SC_F0) begin
                        w_stateNext = GOT_F0;
                    end else if (bus.rx_data == SC_E1) begin
                        w_stateNext   = SKIP;
                        w_skipCntNext = '0;
                    end else if (!(bus.rx_data == 8'h00 || bus.rx_data == SC_BAT_OK ||
                                   bus.rx_data == 8'hFA || bus.rx_data == 8'hFE ||
                                   bus.rx_data == 8'hFF)) begin
                        w_doMake = 1'b1;
                    end
                end
                GOT_E0: begin
                    w_ext = 1'b1;
                    if (bus.rx_data == SC_F0) begin
                        w_stateNext = GOT_E0_F0;
                    end else begin
                        w_doMake    = 1'b1;
                        w_stateNext = IDLE;
                    end
                end
                GOT_F0: begin
                    w_doBreak   = 1'b1;
                    w_stateNext = IDLE;
                end
                GOT_E0_F0: begin
                    w_ext       = 1'b1;
                    w_doBreak   = 1'b1;
                    w_stateNext = IDLE;
                end
                SKIP: begin
                    if (r_skipCnt == CW'(SKIP_E1 - 1)) begin
                        w_skipCntNext = '0;
                        w_stateNext   = IDLE;
                    end else begin
                        w_skipCntNext = r_skipCnt + 1'b1;
                    end
                end
                default: w_stateNext = IDLE;
            endcase
        end

        if (w_doMake) begin
            if (!w_ext && bus.rx_data == SC_LSHIFT) begin
                w_shiftLNext = 1'b1;
            end else if (!w_ext && bus.rx_data == SC_RSHIFT) begin
                w_shiftRNext = 1'b1;
            end else if (w_mapped) begin
                w_keyCodeNext   = {8'h00, w_lutCode};
                w_heldNext      = {w_ext, bus.rx_data};
                w_heldValidNext = 1'b1;
            end
        end

        if (w_doBreak) begin
            if (!w_ext && bus.rx_data == SC_LSHIFT) w_shiftLNext = 1'b0;
            if (!w_ext && bus.rx_data == SC_RSHIFT) w_shiftRNext = 1'b0;
            if (r_heldValid && r_held == {w_ext, bus.rx_data}) begin
                w_keyCodeNext   = 16'h0000;
                w_heldValidNext = 1'b0;
                w_heldNext      = 9'h000;
            end
        end
    end

    assign bus.key_code  = r_keyCode;
    assign bus.key_event = r_keyEvent;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomised and directed stimulus against a keyboard-level reference model with an event scoreboard.
module tb_ps2_scancode_decoder;

    localparam int SKIP_N = 7;

    typedef struct {
        logic [15:0] code;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    ps2_scancode_decoder_if bus();

    ps2_scancode_decoder #(.SKIP_E1(SKIP_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t expQ[$];
    int   lastExp  = 0;

    int   lowMap[int];
    int   highMap[int];
    bit   mPrefE0, mPrefF0, mShiftL, mShiftR, mHeldValid;
    int   mSkip, mHeld, mCode;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic addKey(input int id, input string s);
        lowMap[id]  = s[0];
        highMap[id] = s[1];
    endtask

    task automatic addSpecial(input int id, input int code);
        lowMap[id]  = code;
        highMap[id] = code;
    endtask

    function automatic void setCode(input int v);
        exp_t e;
        if (v != mCode) begin
            e.code = v[15:0];
            e.cyc  = cyc + 1;
            expQ.push_back(e);
        end
        mCode = v;
    endfunction

    // Keyboard-level view: a key goes down or up; shifts are tracked, only the last mapped key is shown.
    function automatic void keyAction(input bit ext, input bit brk, input int sc);
        int id = (ext ? 256 : 0) + sc;
        if (!brk) begin
            if (!ext && sc == 'h12)      mShiftL = 1;
            else if (!ext && sc == 'h59) mShiftR = 1;
            else if (lowMap.exists(id)) begin
                setCode((mShiftL || mShiftR) ? highMap[id] : lowMap[id]);
                mHeld      = id;
                mHeldValid = 1;
            end
        end else begin
            if (!ext && sc == 'h12) mShiftL = 0;
            if (!ext && sc == 'h59) mShiftR = 0;
            if (mHeldValid && mHeld == id) begin
                setCode(0);
                mHeldValid = 0;
            end
        end
    endfunction

    function automatic void modelByte(input logic [7:0] b);
        if (mSkip > 0) begin
            mSkip--;
        end else if (!mPrefE0 && !mPrefF0) begin
            if (b == 8'hE0)      mPrefE0 = 1;
            else if (b == 8'hF0) mPrefF0 = 1;
            else if (b == 8'hE1) mSkip = SKIP_N;
            else if (!(b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF})) keyAction(0, 0, b);
        end else if (mPrefE0 && !mPrefF0) begin
            if (b == 8'hF0) mPrefF0 = 1;
            else begin
                keyAction(1, 0, b);
                mPrefE0 = 0;
            end
        end else begin
            keyAction(mPrefE0, 1, b);
            mPrefE0 = 0;
            mPrefF0 = 0;
        end
    endfunction

    function automatic void modelReset();
        mPrefE0 = 0; mPrefF0 = 0; mSkip = 0;
        mShiftL = 0; mShiftR = 0; mHeldValid = 0; mHeld = 0; mCode = 0;
        expQ.delete();
        lastExp = 0;
    endfunction

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        modelByte(b);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(b);
        if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 2));
    endtask

    // Monitor: every DUT event pops the next expected change; otherwise the output must hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            checkOutput("reset_code", bus.key_code, 0);
            checkOutput("reset_event", bus.key_event, 0);
        end else begin
            while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
                e = expQ.pop_front();
                checkOutput("missing_event", 0, e.code);
                lastExp = e.code;
            end
            if (bus.key_event) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_event", bus.key_code, lastExp);
                    if (bus.key_code == lastExp) begin
                        failures++;
                        $display("[TB] FAIL spurious_event: got event with code %0d, expected no event", bus.key_code);
                    end
                end else begin
                    e = expQ.pop_front();
                    checkOutput("event_code", bus.key_code, e.code);
                    checkOutput("event_cycle", cyc, e.cyc);
                    lastExp = e.code;
                end
            end else begin
                checkOutput("hold_code", bus.key_code, lastExp);
            end
        end
    end

    initial begin
        int fk[12] = '{'h05, 'h06, 'h04, 'h0C, 'h03, 'h0B, 'h83, 'h0A, 'h01, 'h09, 'h78, 'h07};
        byte unsigned pool[30] = '{'h1C, 'h32, 'h21, 'h16, 'h1E, 'h45, 'h4E, 'h52, 'h29, 'h5A,
                                   'h66, 'h76, 'h05, 'h07, 'h78, 'h83, 'h12, 'h59, 'h75, 'h6B,
                                   'h74, 'h72, 'h6C, 'h69, 'h7D, 'h7A, 'h70, 'h71, 'h4A, 'h0D};

        addKey('h1C, "aA"); addKey('h32, "bB"); addKey('h21, "cC"); addKey('h23, "dD");
        addKey('h24, "eE"); addKey('h2B, "fF"); addKey('h34, "gG"); addKey('h33, "hH");
        addKey('h43, "iI"); addKey('h3B, "jJ"); addKey('h42, "kK"); addKey('h4B, "lL");
        addKey('h3A, "mM"); addKey('h31, "nN"); addKey('h44, "oO"); addKey('h4D, "pP");
        addKey('h15, "qQ"); addKey('h2D, "rR"); addKey('h1B, "sS"); addKey('h2C, "tT");
        addKey('h3C, "uU"); addKey('h2A, "vV"); addKey('h1D, "wW"); addKey('h22, "xX");
        addKey('h35, "yY"); addKey('h1A, "zZ");
        addKey('h16, "1!"); addKey('h1E, "2@"); addKey('h26, "3#"); addKey('h25, "4$");
        addKey('h2E, "5%"); addKey('h36, "6^"); addKey('h3D, "7&"); addKey('h3E, "8*");
        addKey('h46, "9("); addKey('h45, "0)");
        lowMap['h0E] = 96; highMap['h0E] = 126;
        addKey('h4E, "-_"); addKey('h55, "=+"); addKey('h54, "[{"); addKey('h5B, "]}");
        addKey('h5D, "\\|"); addKey('h4C, ";:"); addKey('h52, "'\""); addKey('h41, ",<");
        addKey('h49, ".>"); addKey('h4A, "/?"); addKey('h29, "  ");
        addSpecial('h05A, 128); addSpecial('h15A, 128); addSpecial('h066, 129);
        addSpecial('h16B, 130); addSpecial('h175, 131); addSpecial('h174, 132); addSpecial('h172, 133);
        addSpecial('h16C, 134); addSpecial('h169, 135); addSpecial('h17D, 136); addSpecial('h17A, 137);
        addSpecial('h170, 138); addSpecial('h171, 139); addSpecial('h076, 140);
        for (int i = 0; i < 12; i++) addSpecial(fk[i], 141 + i);

        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        modelReset();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        applyStimulus(8'h1C); idleCycles(2);
        checkOutput("tp1_a_make", bus.key_code, 97);
        applyStimulus(8'hF0); applyStimulus(8'h1C); idleCycles(2);
        checkOutput("tp1_a_break", bus.key_code, 0);

        applyStimulus(8'h12); applyStimulus(8'h1C); idleCycles(2);
        checkOutput("tp2_shift_a", bus.key_code, 65);
        applyStimulus(8'hF0); applyStimulus(8'h1C); applyStimulus(8'hF0); applyStimulus(8'h12);
        applyStimulus(8'h1C); idleCycles(2);
        checkOutput("tp2_a_after_shift", bus.key_code, 97);
        applyStimulus(8'hF0); applyStimulus(8'h1C); idleCycles(1);

        applyStimulus(8'hE0); applyStimulus(8'h75); idleCycles(2);
        checkOutput("tp3_up", bus.key_code, 131);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75); idleCycles(2);
        checkOutput("tp3_up_break", bus.key_code, 0);
        applyStimulus(8'h1C); applyStimulus(8'hE0); applyStimulus(8'h75);
        applyStimulus(8'hF0); applyStimulus(8'h1C); idleCycles(2);
        checkOutput("tp3_stale_break", bus.key_code, 131);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75); idleCycles(1);

        applyStimulus(8'h1C);
        applyStimulus(8'hE1); applyStimulus(8'h14); applyStimulus(8'h77); applyStimulus(8'hE1);
        applyStimulus(8'hF0); applyStimulus(8'h14); applyStimulus(8'hF0); applyStimulus(8'h77);
        idleCycles(1);
        checkOutput("tp4_pause_hold", bus.key_code, 97);
        applyStimulus(8'h32); idleCycles(2);
        checkOutput("tp4_b", bus.key_code, 98);
        applyStimulus(8'hF0); applyStimulus(8'h32); idleCycles(1);

        applyStimulus(8'hAA); applyStimulus(8'hFA); idleCycles(1);
        checkOutput("tp5_ignored", bus.key_code, 0);
        applyStimulus(8'h07); idleCycles(2);
        checkOutput("tp5_f12", bus.key_code, 152);

        applyStimulus(8'hE0); idleCycles(1);
        #2 rst_n = 1'b0;
        modelReset();
        @(negedge clk);
        checkOutput("tp6_in_reset", bus.key_code, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(8'h75); idleCycles(2);
        checkOutput("tp6_after_reset", bus.key_code, 0);

        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 9) < 8) begin
                bit ext = ($urandom_range(0, 3) == 0);
                bit brk = ($urandom_range(0, 1) == 0);
                if (ext) sendByte(8'hE0);
                if (brk) sendByte(8'hF0);
                sendByte(pool[$urandom_range(0, 29)]);
            end else begin
                case ($urandom_range(0, 3))
                    0:       sendByte(8'hE1);
                    1:       sendByte(8'hAA);
                    2:       sendByte(8'hFA);
                    default: sendByte(8'($urandom));
                endcase
            end
        end

        idleCycles(4);
        checkOutput("drain_pending", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Converts the raw PS/2 Scan Code Set 2 byte stream into the 16-bit Hack keyboard word. It sits directly downstream of the PS/2 receiver and upstream of the memory-mapped keyboard register. It handles make, break (F0), extended (E0) and Pause (E1) sequences, and tracks Shift. Its output holds the Hack code of the currently held key, or 0 when no key is held.

## Interface

- `SKIP_E1`, default 7: number of bytes discarded after an E1 prefix (Pause sequence).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  scan code byte from the receiver; sampled only when `rx_valid` is high.
- `rx_valid`  in  1  one-cycle strobe marking a new byte.
- `key_code`  out  16  Hack key code of the held key; bits 15:8 are always 0.
- `key_event`  out  1  one-cycle pulse whenever `key_code` changes value.

## Operation

- FSM states:
  - `IDLE`
  - `GOT_E0`
  - `GOT_F0`
  - `GOT_E0_F0`
  - `SKIP` (byte counter 0..SKIP_E1-1)
- State transitions and actions apply only on cycles with `rx_valid=1`.
- **IDLE:**
  - E0 → GOT_E0.
  - F0 → GOT_F0.
  - E1 → SKIP with counter cleared.
  - 00, AA, FA, FE, FF → ignored, stay in IDLE.
  - Any other byte → make(ext=0, byte).
- **GOT_E0:** F0 → GOT_E0_F0; otherwise make(ext=1, byte) → IDLE.
- **GOT_F0:** break(ext=0, byte) → IDLE.
- **GOT_E0_F0:** break(ext=1, byte) → IDLE.
- **SKIP:** each byte increments the counter; the byte that brings the count to SKIP_E1 returns the FSM to IDLE. No key effects occur during SKIP.
- **make(ext, sc):**
  - Non-extended 12 or 59 sets `shift_l` or `shift_r` respectively; `key_code` is unchanged.
  - Extended 12 or 59 is ignored.
  - Mapped key: `key_code` ← LUT(ext, sc, shift), where shift = `shift_l | shift_r`. Held identity ← {ext, sc}.
  - Unmapped key: ignored.
- **break(ext, sc):**
  - Non-extended 12 or 59 clears the corresponding shift bit.
  - If {ext, sc} equals the held identity: `key_code` ← 0 and held identity is cleared.
  - Any other break: no change.
- **Mapping:**
  - Letters: lowercase ASCII 97–122 unshifted, uppercase 65–90 shifted.
  - Digits and punctuation: US-layout ASCII, using shifted symbols when shift is set.
  - Space: 32.
  - Enter (5A, E0 5A): 128.
  - Backspace 66: 129.
  - Arrows: left E0 6B = 130, up E0 75 = 131, right E0 74 = 132, down E0 72 = 133.
  - Home E0 6C = 134, End E0 69 = 135, PgUp E0 7D = 136, PgDn E0 7A = 137.
  - Insert E0 70 = 138, Delete E0 71 = 139.
  - Esc 76: 140.
  - F1–F12: 141–152.
  - Everything else is unmapped.
- Typematic repeat (same make while held): `key_code` is rewritten with the same value, so no `key_event` fires.
- A new make while another key is held replaces both the held identity and `key_code`.
- Shift changes do not re-translate an already-held key.

## Timing

- Reset values:
  - `key_code` = 0, `key_event` = 0.
  - FSM in IDLE, shift bits 0, held identity cleared, SKIP counter 0.
- Reset is asynchronous. Asserting it mid-sequence (e.g. after E0, or during SKIP) discards the partial sequence.
- Latency: `key_code` updates on the clock edge after the cycle in which `rx_valid` is sampled high (1 cycle). `key_event` is high in that same cycle, for exactly one cycle.
- Back-to-back `rx_valid` on consecutive cycles must be accepted without loss. The design has no stall input; the upstream receiver never needs backpressure.
- Bytes arriving while `rx_valid=0` are ignored.

## Structure

- Shared package `hack_keys_pkg` holds:
  - Hack special-key constants (`HK_NEWLINE`=128 … `HK_F12`=152).
  - Scan code constants (`SC_E0`, `SC_E1`, `SC_F0`, `SC_LSHIFT`, `SC_RSHIFT`, `SC_BAT_OK`).
  - The FSM state enumeration.
- Sub-module `scancode_lut`: purely combinational, with inputs {ext, sc[7:0], shift} and outputs {code[7:0], mapped}.
- The top level contains the FSM, SKIP counter, shift and held-key registers, and the output registers.

## Test plan

- Reset, then bytes 1C; F0 1C → `key_code` 97 one cycle after the first strobe, with `key_event` pulsing; after F0 1C, `key_code` = 0 with a second pulse.
- Bytes 12, 1C, F0 1C, F0 12 → `key_code` 65, then 0; shift is cleared afterwards, so a following 1C gives 97.
- Bytes E0 75; E0 F0 75 → 131, then 0. Bytes 1C, E0 75, F0 1C → `key_code` stays 131 after the stale break of A.
- Bytes 1C, then E1 14 77 E1 F0 14 F0 77, then 32 → `key_code` 97 throughout the Pause sequence, then 98 ('b'). The FSM is back in IDLE.
- Bytes AA, FA, then 07 → the first two are ignored (`key_code` 0); 07 gives 152 (F12). Back-to-back strobes on consecutive cycles are exercised within this stimulus.
- Bytes E0, then assert `rst_n`=0 asynchronously, release, then 75 → `key_code` 0 during reset; 75 after release is treated as non-extended (unmapped), so `key_code` remains 0.
